// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: readout port of the acquisition controller.
//   rd_data  - readout sample (signed)
//   rd_valid - rd_data holds a valid sample
//   rd_ready - consumer accepts rd_data on this edge
//   rd_last  - marks the final sample of a window
// master: the controller side, which drives data/valid/last.
// slave:  the consumer side, which drives ready.
interface capture_ctrl_if #(
    parameter int DATA_W = 8
);
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     rd_last;

    modport master (output rd_data, rd_valid, rd_last, input rd_ready);
    modport slave  (input rd_data, rd_valid, rd_last, output rd_ready);
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: acquisition controller behind the trigger stage.
// Continuously records the sample stream into a circular buffer while
// acquiring, waits for a trigger (or a forced trigger on timeout), freezes a
// window of DEPTH samples with a programmable pre-trigger length, and then
// streams that window out oldest-first over a valid/ready port.
//
// Ports:
//   clk     - sample clock, rising edge
//   rst_n   - asynchronous active-low reset
//   data    - signed sample stream (same stream feeding the trigger stage)
//   trig    - trigger pulse, lagging its crossing by TRIG_DELAY samples
//   arm     - start acquisition (honoured only when idle)
//   abort   - return to idle from any state, highest priority
//   single  - 1: stop after one capture, 0: re-arm after readout (latched at arm)
//   auto    - force a trigger after AUTO_CYCLES armed cycles (latched at arm)
//   pretrig - requested pre-trigger sample count (latched at arm)
//   armed   - waiting for a trigger
//   busy    - not idle
//   done    - sticky window-read-out flag, cleared by arm or abort
//   rd      - readout port (capture_ctrl_if master)
module capture_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int TRIG_DELAY  = 8,
    parameter int AUTO_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [7:0]        data,
    input  logic                     trig,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     single,
    input  logic                     auto,
    input  logic        [ADDR_W-1:0] pretrig,
    output logic                     armed,
    output logic                     busy,
    output logic                     done,
    capture_ctrl_if.master           rd
);
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int PRE_MAX = DEPTH - 1 - TRIG_DELAY;
    localparam int ACW     = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    localparam logic [ACW-1:0]    AUTO_LAST = ACW'(AUTO_CYCLES - 1);
    localparam logic [ADDR_W-1:0] TD_A      = ADDR_W'(TRIG_DELAY);
    localparam logic [ADDR_W-1:0] PRE_MAX_A = ADDR_W'(PRE_MAX);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_READ
    } state_t;

    state_t                    state;
    logic        [ADDR_W-1:0]  wp;
    logic        [ADDR_W:0]    fill_cnt;
    logic        [ADDR_W-1:0]  post_cnt;
    logic        [ADDR_W-1:0]  start;
    logic        [ADDR_W-1:0]  pre;
    logic                      single_l;
    logic                      auto_l;
    logic        [ACW-1:0]     auto_cnt;

    logic signed [DATA_W-1:0]  mem [DEPTH];

    // Read pipeline: p1 = RAM read register, p2 = output register.
    logic        [ADDR_W:0]    iss_cnt;
    logic signed [DATA_W-1:0]  data_p1;
    logic                      vld_p1;
    logic                      last_p1;
    logic signed [DATA_W-1:0]  data_p2;
    logic                      vld_p2;
    logic                      last_p2;

    logic        [ADDR_W-1:0]  pre_clamp;
    logic        [ADDR_W:0]    fill_tgt;
    logic        [ADDR_W:0]    fill_nxt;
    logic        [ADDR_W-1:0]  win_start;
    logic        [ADDR_W-1:0]  win_post;
    logic        [ADDR_W-1:0]  rd_addr;
    logic                      trig_hit;
    logic                      wr_en;
    logic                      adv_p1;
    logic                      adv_p2;
    logic                      issue;
    logic                      rd_done;

    assign pre_clamp = (pretrig > PRE_MAX_A) ? PRE_MAX_A : pretrig;
    assign fill_tgt  = {1'b0, pre} + {1'b0, TD_A};
    assign fill_nxt  = fill_cnt + (ADDR_W+1)'(1);
    // The crossing happened TRIG_DELAY samples before the sample written now.
    assign win_start = wp - TD_A - pre;
    assign win_post  = PRE_MAX_A - pre;
    // trig and timeout together still make a single trigger.
    assign trig_hit  = trig || (auto_l && (auto_cnt == AUTO_LAST));
    assign wr_en     = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);

    // Stage p2 may load when empty or being drained; stage p1 may load when
    // empty or moving into p2. This keeps one word per cycle under a
    // continuous rd_ready and freezes both stages during a stall.
    assign adv_p2  = !vld_p2 || rd.rd_ready;
    assign adv_p1  = !vld_p1 || adv_p2;
    assign issue   = (state == S_READ) && (iss_cnt != DEPTH_C) && adv_p1;
    assign rd_addr = start + iss_cnt[ADDR_W-1:0];
    assign rd_done = vld_p2 && rd.rd_ready && last_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wp       <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            start    <= '0;
            pre      <= '0;
            single_l <= 1'b0;
            auto_l   <= 1'b0;
            auto_cnt <= '0;
            armed    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (wr_en) begin
                wp <= wp + ADDR_W'(1);
            end
            if (abort) begin
                state <= S_IDLE;
                armed <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state    <= S_FILL;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pre      <= pre_clamp;
                            single_l <= single;
                            auto_l   <= auto;
                            fill_cnt <= '0;
                            auto_cnt <= '0;
                        end
                    end
                    S_FILL: begin
                        // Also ends the one-cycle done pulse of a re-arm.
                        done     <= 1'b0;
                        fill_cnt <= fill_nxt;
                        if (fill_nxt >= fill_tgt) begin
                            state    <= S_ARMED;
                            armed    <= 1'b1;
                            auto_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (trig_hit) begin
                            start    <= win_start;
                            post_cnt <= win_post;
                            armed    <= 1'b0;
                            state    <= (win_post == '0) ? S_READ : S_POST;
                        end else if (auto_l) begin
                            auto_cnt <= auto_cnt + ACW'(1);
                        end
                    end
                    S_POST: begin
                        post_cnt <= post_cnt - ADDR_W'(1);
                        if (post_cnt == ADDR_W'(1)) begin
                            state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (rd_done) begin
                            done <= 1'b1;
                            if (single_l) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_FILL;
                                fill_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        armed <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Buffer write port and stage p1 synchronous read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= data;
        end
        if (adv_p1) begin
            data_p1 <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            data_p2 <= '0;
        end else if ((state != S_READ) || abort) begin
            iss_cnt <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            // Stage p1: RAM read issue
            if (adv_p1) begin
                vld_p1  <= issue;
                last_p1 <= issue && (iss_cnt == LAST_IDX);
                if (issue) begin
                    iss_cnt <= iss_cnt + (ADDR_W+1)'(1);
                end
            end
            // Stage p2: output register
            if (adv_p2) begin
                vld_p2  <= vld_p1;
                last_p2 <= vld_p1 && last_p1;
                if (vld_p1) begin
                    data_p2 <= data_p1;
                end
            end
        end
    end

    assign rd.rd_data  = data_p2;
    assign rd.rd_valid = vld_p2;
    assign rd.rd_last  = last_p2;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with ADDR_W=5,
// TRIG_DELAY=8, AUTO_CYCLES=50 and a free-running ramp on data.
module tb_capture_ctrl;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'd0;
    logic       trig = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       single = 1'b0;
    logic       auto_en = 1'b0;
    logic [4:0] pretrig = 5'd0;
    logic       armed;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    capture_ctrl_if rd ();

    capture_ctrl #(
        .ADDR_W      (5),
        .TRIG_DELAY  (8),
        .AUTO_CYCLES (50)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .trig    (trig),
        .arm     (arm),
        .abort   (abort),
        .single  (single),
        .auto    (auto_en),
        .pretrig (pretrig),
        .armed   (armed),
        .busy    (busy),
        .done    (done),
        .rd      (rd)
    );

    always #5 clk = ~clk;

    // Ramp: the value visible after #1 is the one sampled at the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            data = data + 8'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_it(input logic [4:0] p, input logic s, input logic a);
        pretrig = p;
        single  = s;
        auto_en = a;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    task automatic wait_armed(output int n);
        n = 0;
        while (!armed && n < 300) begin
            tick();
            n++;
        end
        check("armed_wait", armed, 1);
    endtask

    task automatic pulse_trig_at(input logic [7:0] v);
        int n;
        n = 0;
        while (data != v && n < 300) begin
            tick();
            n++;
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Collects one window; lat = edges from call to first rd_valid.
    task automatic read_window(input logic [7:0] first, input bit rnd, output int lat);
        int         got;
        int         cyc;
        int         stall_left;
        bit         stall_done;
        bit         stalled;
        logic [7:0] held;
        logic [7:0] exp_d;
        got        = 0;
        cyc        = 0;
        lat        = -1;
        stall_left = 0;
        stall_done = 1'b0;
        stalled    = 1'b0;
        held       = 8'd0;
        while (got < DEPTH && cyc < 600) begin
            if (!rnd) begin
                rd.rd_ready = 1'b1;
            end else if (stall_left > 0) begin
                rd.rd_ready = 1'b0;
                stall_left--;
            end else begin
                rd.rd_ready = ($urandom_range(0, 1) == 1);
            end
            #1;
            if (rd.rd_valid && lat < 0) lat = cyc;
            if (stalled) begin
                check("stall_valid", rd.rd_valid, 1);
                check("stall_data", $unsigned(rd.rd_data), held);
            end
            if (rd.rd_valid && rd.rd_ready) begin
                exp_d = first + got[7:0];
                check("rd_data", $unsigned(rd.rd_data), exp_d);
                check("rd_last", rd.rd_last, (got == DEPTH - 1));
                got++;
                if (rnd && got == 10 && !stall_done) begin
                    stall_left = 20;
                    stall_done = 1'b1;
                end
            end
            stalled = rd.rd_valid && !rd.rd_ready;
            held    = rd.rd_data;
            @(posedge clk);
            #2;
            cyc++;
        end
        rd.rd_ready = 1'b0;
        check("xfer_count", got, DEPTH);
    endtask

    initial begin
        int n;
        int lat;
        logic [7:0] d_a;
        bit seen;

        rd.rd_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", rd.rd_valid, 0);
        check("rst_last", rd.rd_last, 0);
        check("rst_data", $unsigned(rd.rd_data), 0);
        check("rst_armed", armed, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Basic capture: pretrig 4, trigger at 100 -> 88..119
        arm_it(5'd4, 1'b1, 1'b0);
        check("t1_busy", busy, 1);
        check("t1_armed_low", armed, 0);
        wait_armed(n);
        pulse_trig_at(8'd100);
        read_window(8'd88, 1'b0, lat);
        check("t1_lat", lat, 21);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);

        // Clamped pretrig 31 -> 23, no POST, trigger at 200 -> 169..200
        arm_it(5'd31, 1'b1, 1'b0);
        check("t2_done_clr", done, 0);
        wait_armed(n);
        pulse_trig_at(8'd200);
        read_window(8'd169, 1'b0, lat);
        check("t2_lat", lat, 2);
        check("t2_done", done, 1);

        // trig during FILL ignored; armed exactly 12 edges after arm
        pretrig = 5'd4;
        single  = 1'b1;
        auto_en = 1'b0;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        n = 0;
        while (!armed && n < 40) begin
            trig = (n == 2 || n == 3 || n == 7 || n == 11);
            tick();
            n++;
        end
        trig = 1'b0;
        check("t3_fill_len", n, 12);
        repeat (3) tick();
        check("t3_still_armed", armed, 1);
        pulse_trig_at(8'd50);
        read_window(8'd38, 1'b0, lat);
        check("t3_lat", lat, 21);

        // Forced trigger 50 cycles after armed rises
        arm_it(5'd4, 1'b1, 1'b1);
        wait_armed(n);
        d_a = data;
        read_window(d_a + 8'd37, 1'b0, lat);
        check("t4_lat", lat, 71);
        check("t4_done", done, 1);

        // auto=0: no capture after 1000 cycles, then abort out of ARMED
        arm_it(5'd4, 1'b1, 1'b0);
        wait_armed(n);
        repeat (1000) tick();
        check("t5_armed", armed, 1);
        check("t5_valid", rd.rd_valid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_armed_low", armed, 0);

        // Random ready with a 20-cycle stall; window wraps 254..29
        arm_it(5'd4, 1'b1, 1'b0);
        wait_armed(n);
        pulse_trig_at(8'd10);
        read_window(8'd254, 1'b1, lat);
        check("t6_lat", lat, 21);
        check("t6_done", done, 1);

        // Continuous mode: re-arm without arm, then abort mid-POST
        arm_it(5'd4, 1'b0, 1'b0);
        wait_armed(n);
        pulse_trig_at(8'd60);
        read_window(8'd48, 1'b0, lat);
        check("t7_done_pulse", done, 1);
        check("t7_busy", busy, 1);
        tick();
        check("t7_done_clr", done, 0);
        wait_armed(n);
        check("t7_refill_len", n, 11);
        pulse_trig_at(8'd150);
        read_window(8'd138, 1'b0, lat);
        wait_armed(n);
        pulse_trig_at(8'd20);
        repeat (5) tick();
        check("t7_in_post", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_abort_busy", busy, 0);
        check("t7_abort_valid", rd.rd_valid, 0);
        check("t7_abort_done", done, 0);
        rd.rd_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | rd.rd_valid;
        end
        rd.rd_ready = 1'b0;
        check("t7_no_valid", seen, 0);

        // Reset asserted mid-READ while stalled
        arm_it(5'd31, 1'b1, 1'b0);
        wait_armed(n);
        pulse_trig_at(8'd100);
        repeat (3) tick();
        check("t8_pre_valid", rd.rd_valid, 1);
        check("t8_pre_data", $unsigned(rd.rd_data), 8'd69);
        #3;
        rst_n = 1'b0;
        #1;
        check("t8_valid", rd.rd_valid, 0);
        check("t8_last", rd.rd_last, 0);
        check("t8_data", $unsigned(rd.rd_data), 0);
        check("t8_armed", armed, 0);
        check("t8_busy", busy, 0);
        check("t8_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
